// File: rtl/reg_bus_master_if.sv
// Host command/response channels plus the register-bus strobe lines of one bus initiator.
// master: the initiator block; slave: the host agent and bus target that surround it.
interface reg_bus_master_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_wr;
   logic [3:0]  cmd_addr;
   logic [3:0]  cmd_len;
   logic [31:0] cmd_wdata;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_last;

   logic        wr_done;
   logic        busy;

   logic        wr_out;
   logic        rd_out;
   logic [3:0]  addr_out;
   logic [31:0] wdata_out;
   logic [31:0] rdata_in;

   modport master (
      input  cmd_valid, cmd_wr, cmd_addr, cmd_len, cmd_wdata,
      input  rsp_ready, rdata_in,
      output cmd_ready, rsp_valid, rsp_data, rsp_last,
      output wr_done, busy, wr_out, rd_out, addr_out, wdata_out
   );

   modport slave (
      output cmd_valid, cmd_wr, cmd_addr, cmd_len, cmd_wdata,
      output rsp_ready, rdata_in,
      input  cmd_ready, rsp_valid, rsp_data, rsp_last,
      input  wr_done, busy, wr_out, rd_out, addr_out, wdata_out
   );
endinterface

// File: rtl/reg_bus_master.sv
// Register-bus initiator: write = strobe one cycle after accept; read beat = rd strobe, RD_LAT wait, response.
// One-entry response buffer: a stalled rsp_ready holds the beat and blocks the next rd strobe.
module reg_bus_master #(
   parameter int unsigned RD_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   reg_bus_master_if.master bus
);
   typedef enum logic [2:0] {IDLE, WR, RD, WAIT, RSP} state_t;

   localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

   state_t      state_q, state_nxt;
   logic [3:0]  addr_q, addr_nxt;
   logic [3:0]  len_q, len_nxt;
   logic [3:0]  beat_q, beat_nxt;
   logic [31:0] wdata_q, wdata_nxt;
   logic [1:0]  wait_q, wait_nxt;

   logic        cmd_ready_q, cmd_ready_nxt;
   logic        rsp_valid_q, rsp_valid_nxt;
   logic        rsp_last_q, rsp_last_nxt;
   logic [31:0] rsp_data_q, rsp_data_nxt;
   logic        wr_done_q, wr_done_nxt;
   logic        busy_q, busy_nxt;
   logic        wr_out_q, wr_out_nxt;
   logic        rd_out_q, rd_out_nxt;
   logic [3:0]  addr_out_q, addr_out_nxt;
   logic [31:0] wdata_out_q, wdata_out_nxt;

   logic accept;

   assign accept = (state_q == IDLE) && bus.cmd_valid && cmd_ready_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         len_q       <= '0;
         beat_q      <= '0;
         wdata_q     <= '0;
         wait_q      <= '0;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_last_q  <= 1'b0;
         rsp_data_q  <= '0;
         wr_done_q   <= 1'b0;
         busy_q      <= 1'b0;
         wr_out_q    <= 1'b0;
         rd_out_q    <= 1'b0;
         addr_out_q  <= '0;
         wdata_out_q <= '0;
      end else begin
         state_q     <= state_nxt;
         addr_q      <= addr_nxt;
         len_q       <= len_nxt;
         beat_q      <= beat_nxt;
         wdata_q     <= wdata_nxt;
         wait_q      <= wait_nxt;
         cmd_ready_q <= cmd_ready_nxt;
         rsp_valid_q <= rsp_valid_nxt;
         rsp_last_q  <= rsp_last_nxt;
         rsp_data_q  <= rsp_data_nxt;
         wr_done_q   <= wr_done_nxt;
         busy_q      <= busy_nxt;
         wr_out_q    <= wr_out_nxt;
         rd_out_q    <= rd_out_nxt;
         addr_out_q  <= addr_out_nxt;
         wdata_out_q <= wdata_out_nxt;
      end
   end

   always_comb begin
      state_nxt    = state_q;
      addr_nxt     = addr_q;
      len_nxt      = len_q;
      beat_nxt     = beat_q;
      wdata_nxt    = wdata_q;
      wait_nxt     = wait_q;
      rsp_data_nxt = rsp_data_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               addr_nxt  = bus.cmd_addr;
               len_nxt   = bus.cmd_len;
               wdata_nxt = bus.cmd_wdata;
               beat_nxt  = 4'd0;
               state_nxt = bus.cmd_wr ? WR : RD;
            end
         end
         WR: begin
            state_nxt = IDLE;
         end
         RD: begin
            wait_nxt  = 2'd0;
            state_nxt = WAIT;
         end
         WAIT: begin
            // rdata_in is only trusted on the last wait cycle
            if (wait_q == WAIT_LAST) begin
               rsp_data_nxt = bus.rdata_in;
               state_nxt    = RSP;
            end else begin
               wait_nxt = wait_q + 2'd1;
            end
         end
         RSP: begin
            if (bus.rsp_ready) begin
               if (beat_q == len_q) begin
                  state_nxt = IDLE;
               end else begin
                  addr_nxt  = addr_q + 4'd1;
                  beat_nxt  = beat_q + 4'd1;
                  state_nxt = RD;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Outputs are decoded from the next state so they line up with the state they belong to.
      cmd_ready_nxt = (state_nxt == IDLE);
      busy_nxt      = (state_nxt != IDLE);
      wr_out_nxt    = (state_nxt == WR);
      wr_done_nxt   = (state_nxt == WR);
      rd_out_nxt    = (state_nxt == RD);
      rsp_valid_nxt = (state_nxt == RSP);
      rsp_last_nxt  = (state_nxt == RSP) && (beat_nxt == len_nxt);
      addr_out_nxt  = ((state_nxt == WR) || (state_nxt == RD)) ? addr_nxt : addr_out_q;
      wdata_out_nxt = (state_nxt == WR) ? wdata_nxt : wdata_out_q;
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_last  = rsp_last_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.wr_done   = wr_done_q;
   assign bus.busy      = busy_q;
   assign bus.wr_out    = wr_out_q;
   assign bus.rd_out    = rd_out_q;
   assign bus.addr_out  = addr_out_q;
   assign bus.wdata_out = wdata_out_q;

   a_strobe_excl: assert property (@(posedge clk) disable iff (!rst) !(wr_out_q && rd_out_q));
   a_rd_single:   assert property (@(posedge clk) disable iff (!rst) rd_out_q |=> !rd_out_q);
endmodule
